// File: rtl/axis_frame_pkg.sv
// ============================================================================
// Module      : axis_frame_pkg
// Description : Shared types and width helpers for the framed AXI-Stream
//               master (FSM state encoding, counter width functions).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_frame_pkg;

    // Frame sequencing states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of the optional output-stall counter
    localparam int STALL_CNT_W = 32;

    // Bits needed to index 0..n-1, never less than one bit
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to count 0..w*h inclusive (accepted-pixel counter)
    function automatic int in_cnt_w(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_frame_master_if.sv
// ============================================================================
// Module      : axis_frame_master_if
// Description : Producer valid/ready pixel port plus AXI-Stream master port
//               of the frame master, with master (block) and slave (peer)
//               modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_frame_master_if #(
    parameter int DATA_WIDTH = 32
);
    // Producer side
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    // AXI-Stream side
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;

    // View from the frame master itself
    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast,
        output m_axis_tuser
    );

    // View from the producer / downstream peers
    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast,
        input  m_axis_tuser
    );

endinterface

`default_nettype wire

// File: rtl/axis_sync_fifo.sv
// ============================================================================
// Module      : axis_sync_fifo
// Description : Small synchronous FIFO with registered storage and
//               wrap-around pointers carrying one extra bit to tell full
//               from empty. Head entry is visible the cycle after its push.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   push,
    input  wire  [DATA_WIDTH-1:0] push_data,
    input  wire                   pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]         r_wr_ptr;
    logic [c_AW:0]         r_rd_ptr;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // Writes into a full FIFO and reads from an empty one are dropped
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Storage: cleared on reset so the head reads zero after a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers, independent advance on push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    assign head_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/axis_frame_master.sv
// ============================================================================
// Module      : axis_frame_master
// Description : Converts a valid/ready pixel producer into a framed
//               AXI-Stream master. One frame of FRAME_WIDTH x FRAME_HEIGHT
//               beats runs per frame_start; tuser marks the first beat of
//               the frame, tlast the last beat of each line. A small FIFO
//               absorbs downstream backpressure.
//               Optional build macro AXIS_FRAME_STALL_CNT_EN adds the
//               stall_cycles output (saturating tvalid && !tready count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_frame_master
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_WIDTH  = 512,
    parameter int FRAME_HEIGHT = 512,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire                     clk,
    input  wire                     rst,
    input  wire                     frame_start,
    output logic                    frame_done,
    output logic                    busy,
`ifdef AXIS_FRAME_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0]  stall_cycles,
`endif
    axis_frame_master_if.master     bus
);

    localparam int c_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int c_IN_W   = in_cnt_w(FRAME_WIDTH, FRAME_HEIGHT);
    localparam int c_COL_W  = cnt_w(FRAME_WIDTH);
    localparam int c_ROW_W  = cnt_w(FRAME_HEIGHT);

    localparam logic [c_IN_W-1:0]  c_IN_LAST  = c_IN_W'(c_PIXELS - 1);
    localparam logic [c_IN_W-1:0]  c_IN_ONE   = c_IN_W'(1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(FRAME_WIDTH - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_IN_W-1:0]     r_in_cnt;
    logic [c_COL_W-1:0]    r_col_cnt;
    logic [c_ROW_W-1:0]    r_row_cnt;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_beat;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_head;

    // Frame accepted only from IDLE; frame_start elsewhere has no effect
    assign w_accept = (r_state == IDLE) && frame_start;

    // Producer side: accept only while filling and there is room
    assign bus.in_ready = (r_state == FILL) && !w_fifo_full;
    assign w_push       = bus.in_valid && bus.in_ready;

    // Stream side: valid whenever the frame is active and data is buffered
    assign bus.m_axis_tvalid = ((r_state == FILL) || (r_state == DRAIN)) && !w_fifo_empty;
    assign bus.m_axis_tdata  = w_fifo_head;
    assign w_pop             = bus.m_axis_tvalid && bus.m_axis_tready;

    // Flags derive from handshake-only counters, so they hold while stalled
    assign bus.m_axis_tuser = bus.m_axis_tvalid && (r_col_cnt == '0) && (r_row_cnt == '0);
    assign bus.m_axis_tlast = bus.m_axis_tvalid && (r_col_cnt == c_COL_LAST);
    assign w_last_beat      = (r_col_cnt == c_COL_LAST) && (r_row_cnt == c_ROW_LAST);

    assign frame_done = (r_state == DONE);
    assign busy       = (r_state != IDLE);

    axis_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (bus.in_data),
        .pop       (w_pop),
        .head_data (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: FILL until the last pixel is pushed, DRAIN until
    // the last beat leaves, then a single DONE cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (frame_start) w_state_next = FILL;
            FILL:    if (w_push && (r_in_cnt == c_IN_LAST)) w_state_next = DRAIN;
            DRAIN:   if (w_pop && w_last_beat) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Pixel, column and row counters; column/row move only on a handshake
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_in_cnt  <= '0;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else begin
            if (w_push) begin
                r_in_cnt <= r_in_cnt + c_IN_ONE;
            end
            if (w_pop) begin
                if (r_col_cnt == c_COL_LAST) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= (r_row_cnt == c_ROW_LAST) ? '0 : (r_row_cnt + c_ROW_ONE);
                end else begin
                    r_col_cnt <= r_col_cnt + c_COL_ONE;
                end
            end
        end
    end

`ifdef AXIS_FRAME_STALL_CNT_EN
    localparam logic [STALL_CNT_W-1:0] c_STALL_ONE = STALL_CNT_W'(1);

    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Saturating count of stalled output cycles, held until the next frame
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_stall_cnt <= '0;
        end else if (bus.m_axis_tvalid && !bus.m_axis_tready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_master.sv
// ============================================================================
// Module      : tb_axis_frame_master
// Description : Self-checking bench for axis_frame_master (W=4, H=2,
//               FIFO_DEPTH=4) against a count/queue-based frame model.
//               Build with AXIS_FRAME_STALL_CNT_EN to also cover
//               stall_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_frame_master;

    localparam int c_W     = 4;
    localparam int c_H     = 2;
    localparam int c_N     = c_W * c_H;
    localparam int c_DEPTH = 4;
    localparam int c_DW    = 32;

    logic clk;
    logic rst;
    logic frame_start;
    logic frame_done;
    logic busy;
`ifdef AXIS_FRAME_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    axis_frame_master_if #(.DATA_WIDTH(c_DW)) bus ();

    axis_frame_master #(
        .DATA_WIDTH   (c_DW),
        .FRAME_WIDTH  (c_W),
        .FRAME_HEIGHT (c_H),
        .FIFO_DEPTH   (c_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .busy         (busy),
`ifdef AXIS_FRAME_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frame active/done flags, accepted and emitted counts
    bit          m_active;
    bit          m_done;
    int          m_acc;
    int          m_pop;
    logic [31:0] m_q[$];
    logic [31:0] m_stall;

    // Observed activity accumulated across steps
    int g_push = 0;
    int g_beat = 0;
    int g_done = 0;
    bit g_saw_full;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_done   = 0;
        m_acc    = 0;
        m_pop    = 0;
        m_q.delete();
        m_stall  = '0;
    endtask

    // One clock: drive inputs, compare outputs to the model, advance model
    task automatic step(input bit fs, input bit iv, input logic [31:0] id,
                        input bit tr, input bit r);
        int occ;
        bit e_busy, e_rdy, e_val, e_user, e_last;
        frame_start        = fs;
        bus.in_valid       = iv;
        bus.in_data        = id;
        bus.m_axis_tready  = tr;
        rst                = r;
        #1;
        occ    = m_acc - m_pop;
        e_busy = m_active || m_done;
        e_rdy  = m_active && (m_acc < c_N) && (occ < c_DEPTH);
        e_val  = m_active && (occ > 0);
        e_user = e_val && (m_pop == 0);
        e_last = e_val && ((m_pop % c_W) == c_W - 1);
        check("busy",       busy,              e_busy);
        check("in_ready",   bus.in_ready,      e_rdy);
        check("tvalid",     bus.m_axis_tvalid, e_val);
        check("tuser",      bus.m_axis_tuser,  e_user);
        check("tlast",      bus.m_axis_tlast,  e_last);
        check("frame_done", frame_done,        m_done);
        if (e_val) check("tdata", bus.m_axis_tdata, m_q[m_pop]);
`ifdef AXIS_FRAME_STALL_CNT_EN
        check("stall_cycles", stall_cycles, m_stall);
`endif
        if (iv && bus.in_ready) g_push++;
        if (bus.m_axis_tvalid && tr) g_beat++;
        if (frame_done) g_done++;
        if (!bus.in_ready && m_active && (m_acc < c_N)) g_saw_full = 1;

        if (r) begin
            model_reset();
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (fs) begin
                m_active = 1;
                m_acc    = 0;
                m_pop    = 0;
                m_q.delete();
                m_stall  = '0;
            end
        end else begin
            if (e_val && !tr && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
            if (iv && e_rdy) begin
                m_q.push_back(id);
                m_acc++;
            end
            if (e_val && tr) begin
                m_pop++;
                if (m_pop == c_N) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    // mode 0 basic, 1 backpressure, 2 bubbles, 3 ignored inputs, 4 reset mid-frame
    task automatic run_frame(input int mode, input logic [31:0] base);
        int cyc, first_pop, prev_pop, push0, beat0, done0;
        bit fs, iv, tr, r;
        push0 = g_push;
        beat0 = g_beat;
        done0 = g_done;
        g_saw_full = 0;
        first_pop  = -1;
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        cyc = 0;
        while ((m_active || m_done) && cyc < 300) begin
            fs = 0;
            iv = m_active && (m_acc < c_N);
            tr = 1;
            r  = 0;
            case (mode)
                1: tr = !((first_pop >= 0) && (cyc > first_pop) && (cyc <= first_pop + 10));
                2: begin
                    iv = iv && (cyc[0] == 1'b0);
                    tr = 1'($urandom_range(0, 1));
                end
                3: begin
                    tr = (cyc % 2 == 1);
                    if (m_done || (m_active && m_acc == c_N)) begin
                        fs = 1;
                        iv = 1;
                    end
                end
                4: r = (m_pop == 3);
                default: ;
            endcase
            prev_pop = m_pop;
            step(fs, iv, base + 32'(m_acc), tr, r);
            if (prev_pop == 0 && m_pop == 1) first_pop = cyc;
            cyc++;
        end
        check("frame_timeout", cyc < 300, 1'b1);
        if (mode == 4) begin
            check("done_after_rst", g_done - done0, 0);
        end else begin
            check("pushes",      g_push - push0, c_N);
            check("beats",       g_beat - beat0, c_N);
            check("done_pulses", g_done - done0, 1);
        end
        if (mode == 1) begin
            check("fifo_full_seen", g_saw_full, 1'b1);
`ifdef AXIS_FRAME_STALL_CNT_EN
            check("stall_total", stall_cycles, 10);
`endif
        end
    endtask

    initial begin
        rst               = 1'b1;
        frame_start       = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.m_axis_tready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tdata", bus.m_axis_tdata, 0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        // in_valid without frame_start in IDLE is ignored
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);

        run_frame(0, 32'd1);
        run_frame(1, 32'd1);
        run_frame(2, 32'd1);
        run_frame(3, 32'd1);
        repeat (3) step(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0);

        run_frame(4, 32'd1);
        check("rst_mid_tdata", bus.m_axis_tdata, 0);
        run_frame(0, 32'd1);

        // back-to-back frames: frame_start in the cycle after frame_done
        run_frame(0, $urandom);
        run_frame(2, $urandom);
        run_frame(1, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/axis_frame_master.md
Name: axis_frame_master

Overview:
- Upstream neighbour of the AXI-Stream pixel slave: converts a simple valid/ready pixel producer into a framed AXI-Stream master.
- Marks start of frame on `tuser` and end of line on `tlast`.
- Buffers pixels in a small synchronous FIFO to absorb downstream backpressure.
- Runs one frame per `frame_start` pulse and reports completion with `frame_done`.

Parameters:
- DATA_WIDTH, 32, pixel/beat width
- FRAME_WIDTH, 512, beats per line (>=2)
- FRAME_HEIGHT, 512, lines per frame (>=1)
- FIFO_DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse that arms a new frame; honoured only in IDLE
- in_data  in  DATA_WIDTH  producer pixel
- in_valid  in  1  producer pixel valid
- in_ready  out  1  block accepts pixel this cycle
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of line
- m_axis_tuser  out  1  first beat of frame
- frame_done  out  1  one-cycle pulse after the final beat handshakes
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: one clock and one reset, synchronous and active-high. On rst, at the clock edge:
  - state=IDLE; FIFO flushed; all counters cleared.
  - in_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, frame_done=0, busy=0.
- States: IDLE -> FILL -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=0.
  - frame_start=1 moves to FILL next cycle and clears all counters.
- FILL:
  - in_ready = !fifo_full. Push happens when in_valid && in_ready.
  - in_cnt counts accepted pixels. Its width is $clog2(FRAME_WIDTH*FRAME_HEIGHT+1).
  - When the push with in_cnt == W*H-1 occurs, go to DRAIN. in_ready=0 from the next cycle.
- DRAIN:
  - in_ready=0.
  - When the last output beat handshakes, go to DONE.
- DONE:
  - frame_done=1 for exactly this one cycle, then IDLE.
- Output handshake (valid in FILL and DRAIN):
  - m_axis_tvalid = !fifo_empty. m_axis_tdata = FIFO head.
  - A beat transfers when tvalid && tready.
- Counters:
  - col_cnt ($clog2(W) bits) and row_cnt ($clog2(H), min 1 bit) advance only on an output handshake.
  - col wraps from W-1 to 0 and increments row.
  - row_cnt==H-1 with col==W-1 is the final beat.
- Flags:
  - m_axis_tuser = tvalid && col==0 && row==0.
  - m_axis_tlast = tvalid && col==W-1.
- AXI-Stream rule: once tvalid=1, tdata/tlast/tuser stay stable and tvalid stays high until tready=1. Counters only move on a handshake, which guarantees this.
- Latency:
  - A pixel pushed at cycle N is visible on m_axis at N+1 when the FIFO was empty (registered FIFO).
  - Throughput is 1 beat/cycle with tready held high.
- FIFO full: in_ready=0. A push is not allowed at full even if a pop happens in the same cycle.
- Empty FIFO with simultaneous push and pop: not possible, since tvalid=0 when empty.
- Same-cycle push and pop when neither full nor empty: occupancy unchanged.
- frame_start outside IDLE: ignored, with no effect on counters.
- in_valid while in IDLE, DRAIN or DONE: ignored; no data is captured.
- Reset mid-frame: frame is aborted and all buffered data is discarded. tvalid is 0 in the cycle after reset, and frame_done is not pulsed.

Optional Feature:
- Macro: AXIS_FRAME_STALL_CNT_EN.
- When defined:
  - Extra output port `stall_cycles`, 32 bits.
  - It counts cycles with m_axis_tvalid && !m_axis_tready during the current frame.
  - Cleared on rst and on frame accept (IDLE with frame_start); saturates at 2^32-1.
  - It holds its value after DONE until the next frame_start.
- When not defined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package `axis_frame_pkg`:
  - state_t enum (IDLE, FILL, DRAIN, DONE), 2 bits.
  - Localparam helpers for counter widths.
  - STALL_CNT_W=32.
- Sub-module `axis_sync_fifo`:
  - Parameters: DATA_WIDTH, DEPTH.
  - Ports: clk, rst, push, push_data, pop, head_data, full, empty.
  - Registered storage, wrap-around read/write pointers plus one extra bit for the full/empty distinction, synchronous active-high reset.

Test Plan (W=4, H=2, FIFO_DEPTH=4):
- Basic frame: frame_start, producer sends 1..8 back-to-back, tready=1.
  - Expect 8 beats with data 1..8.
  - tuser only on data 1; tlast on data 4 and 8.
  - frame_done pulses 1 cycle after beat 8; busy drops with it.
- Backpressure: tready=0 for 10 cycles after the first beat.
  - FIFO fills to 4 and in_ready=0.
  - tdata/tuser/tlast are held while stalled.
  - After release, data order is 1..8 with none lost.
  - With AXIS_FRAME_STALL_CNT_EN defined, stall_cycles=10.
- Producer bubbles: in_valid toggles 1/0 and tready is random.
  - Output sequence 1..8 and tlast positions unchanged.
  - Exactly 8 pixels accepted; in_ready=0 after the 8th.
- Ignored inputs: frame_start and in_valid pulsed in DRAIN.
  - No extra beats; frame_done pulses once; state returns to IDLE.
  - Pulses in IDLE without frame_start do not move the state.
- Reset mid-frame: assert rst after beat 3.
  - Next cycle: tvalid=0, busy=0, no frame_done.
  - A new frame then starts with tuser on its first beat and col/row at 0.
- Back-to-back frames: frame_start in the cycle right after frame_done.
  - Second frame is accepted; tuser appears on its beat 1; tlast pattern repeats.
